// File: rtl/pair_accum_stage.sv
// pair_accum_stage: accumulates the AND-path and OR-path operands of a burst
// of up to BURST_LEN beats and presents the two sums plus the beat count as a
// single held result with a valid/ready handshake.
//
// Optional feature: define PAIR_ACCUM_SAT_EN to make both accumulators
// saturate at 2^ACC_W-1 instead of wrapping modulo 2^ACC_W.
module pair_accum_stage #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ACC_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum_a,
  output logic [ACC_W-1:0] out_sum_b,
  output logic [7:0]       out_count
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_a_q, acc_b_q;
  logic [7:0]       count_q;
  logic             out_valid_q;

  logic             accept;
  logic             burst_end;
  logic [ACC_W-1:0] base_a, base_b;
  logic [ACC_W-1:0] zext_a, zext_b;
  logic [ACC_W-1:0] acc_a_d, acc_b_d;
  logic [7:0]       count_d;
`ifdef PAIR_ACCUM_SAT_EN
  logic [ACC_W:0]   sum_a, sum_b;
`endif

  assign in_ready  = (state_q != StDone);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_sum_a = acc_a_q;
  assign out_sum_b = acc_b_q;
  assign out_count = count_q;

  // Next accumulator/count values for an accepted beat; IDLE starts from zero.
  always_comb begin
    base_a  = (state_q == StIdle) ? '0 : acc_a_q;
    base_b  = (state_q == StIdle) ? '0 : acc_b_q;
    zext_a  = ACC_W'(in_a);
    zext_b  = ACC_W'(in_b);
`ifdef PAIR_ACCUM_SAT_EN
    sum_a   = {1'b0, base_a} + {1'b0, zext_a};
    sum_b   = {1'b0, base_b} + {1'b0, zext_b};
    // Once at the ceiling every further add carries out, so the value holds.
    acc_a_d = sum_a[ACC_W] ? '1 : sum_a[ACC_W-1:0];
    acc_b_d = sum_b[ACC_W] ? '1 : sum_b[ACC_W-1:0];
`else
    acc_a_d = base_a + zext_a;
    acc_b_d = base_b + zext_b;
`endif
    count_d   = (state_q == StIdle) ? 8'd1 : count_q + 8'd1;
    burst_end = in_last || (count_d == 8'(BURST_LEN));
  end

  // Burst FSM with registered result and out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            acc_a_q <= acc_a_d;
            acc_b_q <= acc_b_d;
            count_q <= count_d;
            if (burst_end) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pair_accum_stage.sv
// Directed bench for pair_accum_stage: three instances cover the default
// configuration, an 8-bit accumulator for overflow, and single-beat bursts.
module tb_pair_accum_stage;

  logic        clk;
  logic        rst;
  logic [7:0]  in_a, in_b;
  logic        in_last;
  logic        out_ready;

  logic        in_valid0, in_ready0, out_valid0;
  logic [11:0] out_sum_a0, out_sum_b0;
  logic [7:0]  out_count0;

  logic        in_valid1, in_ready1, out_valid1;
  logic [7:0]  out_sum_a1, out_sum_b1;
  logic [7:0]  out_count1;

  logic        in_valid2, in_ready2, out_valid2;
  logic [11:0] out_sum_a2, out_sum_b2;
  logic [7:0]  out_count2;

  int n_cmp;
  int n_err;

  pair_accum_stage #(.BURST_LEN(4), .ACC_W(12)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_sum_a(out_sum_a0), .out_sum_b(out_sum_b0),
    .out_count(out_count0)
  );

  pair_accum_stage #(.BURST_LEN(4), .ACC_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum_a(out_sum_a1), .out_sum_b(out_sum_b1),
    .out_count(out_count1)
  );

  pair_accum_stage #(.BURST_LEN(1), .ACC_W(12)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_sum_a(out_sum_a2), .out_sum_b(out_sum_b2),
    .out_count(out_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Present one beat to instance idx; it is accepted on the next rising edge.
  task automatic beat(input int idx, input logic [7:0] a, input logic [7:0] b,
                      input logic last);
    in_a    = a;
    in_b    = b;
    in_last = last;
    case (idx)
      0:       begin in_valid0 = 1'b1; chk("beat_in_ready0", in_ready0, 1); end
      1:       begin in_valid1 = 1'b1; chk("beat_in_ready1", in_ready1, 1); end
      default: begin in_valid2 = 1'b1; chk("beat_in_ready2", in_ready2, 1); end
    endcase
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
    in_last   = 1'b0;
  endtask

  logic [31:0] ovf_exp;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;

    // Reset values
    #12;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_sum_a", out_sum_a0, 0);
    chk("rst_sum_b", out_sum_b0, 0);
    chk("rst_count", out_count0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready0, 1);

    // Full burst of four back-to-back beats
    beat(0, 8'd1, 8'd2, 1'b0);
    beat(0, 8'd3, 8'd4, 1'b0);
    beat(0, 8'd5, 8'd6, 1'b0);
    beat(0, 8'd7, 8'd8, 1'b0);
    @(negedge clk);
    chk("full_out_valid", out_valid0, 1);
    chk("full_in_ready", in_ready0, 0);
    chk("full_sum_a", out_sum_a0, 16);
    chk("full_sum_b", out_sum_b0, 20);
    chk("full_count", out_count0, 4);
    @(posedge clk);
    #1;
    chk("full_drained_valid", out_valid0, 0);
    chk("full_drained_ready", in_ready0, 1);

    // Short burst ended by in_last, then held under backpressure
    out_ready = 1'b0;
    beat(0, 8'd10, 8'd20, 1'b0);
    beat(0, 8'd30, 8'd40, 1'b1);
    @(negedge clk);
    chk("short_out_valid", out_valid0, 1);
    chk("short_sum_a", out_sum_a0, 40);
    chk("short_sum_b", out_sum_b0, 60);
    chk("short_count", out_count0, 2);

    in_a      = 8'd99;
    in_b      = 8'd99;
    in_valid0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready0, 0);
      chk("bp_out_valid", out_valid0, 1);
      chk("bp_sum_a", out_sum_a0, 40);
      chk("bp_sum_b", out_sum_b0, 60);
      chk("bp_count", out_count0, 2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("handoff_out_valid", out_valid0, 0);
    chk("handoff_in_ready", in_ready0, 1);
    // The 99/99 beat must not have been taken during the handoff cycle.
    in_a    = 8'd5;
    in_b    = 8'd6;
    in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_last   = 1'b0;
    chk("first_last_valid", out_valid0, 1);
    chk("first_last_sum_a", out_sum_a0, 5);
    chk("first_last_sum_b", out_sum_b0, 6);
    chk("first_last_count", out_count0, 1);
    @(posedge clk);
    #1;
    chk("first_last_drained", out_valid0, 0);

    // Reset in the middle of a burst
    beat(0, 8'd50, 8'd50, 1'b0);
    beat(0, 8'd50, 8'd50, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid0, 0);
    chk("mid_rst_sum_a", out_sum_a0, 0);
    chk("mid_rst_count", out_count0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_no_result", out_valid0, 0);
    chk("mid_rst_in_ready", in_ready0, 1);
    for (int i = 0; i < 4; i++) beat(0, 8'd1, 8'd1, 1'b0);
    @(negedge clk);
    chk("after_rst_valid", out_valid0, 1);
    chk("after_rst_sum_a", out_sum_a0, 4);
    chk("after_rst_sum_b", out_sum_b0, 4);
    chk("after_rst_count", out_count0, 4);
    @(posedge clk);
    #1;

    // Overflow on the 8-bit instance
`ifdef PAIR_ACCUM_SAT_EN
    ovf_exp = 255;
`else
    ovf_exp = 252;
`endif
    for (int i = 0; i < 4; i++) beat(1, 8'd255, 8'd255, 1'b0);
    @(negedge clk);
    chk("ovf_out_valid", out_valid1, 1);
    chk("ovf_sum_a", out_sum_a1, ovf_exp);
    chk("ovf_sum_b", out_sum_b1, ovf_exp);
    chk("ovf_count", out_count1, 4);
    @(posedge clk);
    #1;

    // Single-beat bursts
    beat(2, 8'd9, 8'd7, 1'b0);
    @(negedge clk);
    chk("single_out_valid", out_valid2, 1);
    chk("single_sum_a", out_sum_a2, 9);
    chk("single_sum_b", out_sum_b2, 7);
    chk("single_count", out_count2, 1);
    @(posedge clk);
    #1;
    chk("single_drained", out_valid2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
